// File: rtl/shift_unit.sv
// shift_unit: sequential shift/rotate engine with valid/ready handshakes.
// It moves one bit position per clock, so any amount up to 2**AMT_W-1 costs
// amt cycles and no barrel shifter. Results are held in DONE until consumed.
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASL = 3'b010;
  localparam logic [2:0] M_ASR = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;

  state_t           state_q;
  logic [WIDTH-1:0] data_q, shift_d;
  logic             carry_q, carry_d;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [AMT_W-1:0] eff_amt;

  // Pass-through modes (11x) never shift, regardless of in_amt.
  assign eff_amt   = (in_mode[2:1] == 2'b11) ? '0 : in_amt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;

  // One-position step of the working register; carry is the bit that leaves
  // (or wraps) on this step.
  always_comb begin
    shift_d = data_q;
    carry_d = carry_q;
    case (mode_q)
      M_LSL, M_ASL: begin
        shift_d = {data_q[WIDTH-2:0], 1'b0};
        carry_d = data_q[WIDTH-1];
      end
      M_LSR: begin
        shift_d = {1'b0, data_q[WIDTH-1:1]};
        carry_d = data_q[0];
      end
      M_ASR: begin
        shift_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        carry_d = data_q[0];
      end
      M_ROL: begin
        shift_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        carry_d = data_q[WIDTH-1];
      end
      M_ROR: begin
        shift_d = {data_q[0], data_q[WIDTH-1:1]};
        carry_d = data_q[0];
      end
      default: ;
    endcase
  end

  // Control FSM: accept in IDLE, step in BUSY, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      carry_q     <= 1'b0;
      mode_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            cnt_q   <= eff_amt;
            carry_q <= 1'b0;
            if (eff_amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          data_q  <= shift_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed and randomized checks of shift_unit against an
// arithmetic reference model (whole-amount shifts, modulo rotates).
module tb_shift_unit;

  localparam int W = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [A-1:0] in_amt = '0;
  logic [2:0]   in_mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_carry;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  // Reference: the whole operation in one arithmetic step.
  function automatic void model(input logic [W-1:0] d, input int amt_in,
                                input logic [2:0] m,
                                output logic [W-1:0] r, output logic c);
    longint unsigned u, t;
    longint s, st;
    int amt, k;
    amt = (m[2:1] == 2'b11) ? 0 : amt_in;
    u = longint'(d);
    s = longint'($signed(d));
    k = amt % W;
    r = d;
    c = 1'b0;
    case (m)
      3'd0, 3'd2: begin t = u << amt; r = t[W-1:0]; c = t[W]; end
      3'd1: begin
        t = u >> amt; r = t[W-1:0];
        if (amt > 0) begin t = u >> (amt - 1); c = t[0]; end
      end
      3'd3: begin
        st = s >>> amt; r = st[W-1:0];
        if (amt > 0) begin st = s >>> (amt - 1); c = st[0]; end
      end
      3'd4: begin t = (u << k) | (u >> (W - k)); r = t[W-1:0]; if (amt > 0) c = r[0]; end
      3'd5: begin t = (u >> k) | (u << (W - k)); r = t[W-1:0]; if (amt > 0) c = r[W-1]; end
      default: begin r = d; c = 1'b0; end
    endcase
  endfunction

  // Issue one request from a negedge and wait (bounded) for out_valid.
  // lat counts rising edges after the accepting edge.
  task automatic run_op(input logic [W-1:0] d, input logic [A-1:0] a,
                        input logic [2:0] m, output int lat, output bit tmo);
    in_data = d; in_amt = a; in_mode = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    tmo = !out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({out_valid, out_data, out_carry, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%h c=%b rdy=%b, want v=0 d=00 c=0 rdy=1",
               out_valid, out_data, out_carry, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] td[7] = '{8'hB3, 8'h84, 8'h84, 8'h84, 8'h81, 8'h01, 8'h5C};
    logic [A-1:0] ta[7] = '{3'd3, 3'd2, 3'd7, 3'd7, 3'd1, 3'd7, 3'd4};
    logic [2:0]   tm[7] = '{3'd0, 3'd3, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2};
    logic [W-1:0] xd[7] = '{8'h98, 8'hE1, 8'h01, 8'hFF, 8'h03, 8'h02, 8'hC0};
    logic         xc[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat; bit tmo;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL directed%0d ready: got %b want 1", i, in_ready);
      end
      run_op(td[i], ta[i], tm[i], lat, tmo);
      n_checks++;
      if (tmo || lat !== int'(ta[i])) begin
        n_fail++; $display("FAIL directed%0d latency: got %0d (timeout %b) want %0d", i, lat, tmo, ta[i]);
      end
      n_checks++;
      if ({out_data, out_carry} !== {xd[i], xc[i]}) begin
        n_fail++;
        $display("FAIL directed%0d result: got %h/%b want %h/%b", i, out_data, out_carry, xd[i], xc[i]);
      end
      consume();
    end
  endtask

  task automatic test_zero_amt();
    int lat; bit tmo;
    logic [2:0] ms[2] = '{3'b001, 3'b110};
    logic [A-1:0] as[2] = '{3'd0, 3'd5};
    for (int i = 0; i < 2; i++) begin
      run_op(8'hA5, as[i], ms[i], lat, tmo);
      n_checks++;
      if (tmo || lat !== 0) begin
        n_fail++; $display("FAIL zero_amt%0d latency: got %0d want 0", i, lat);
      end
      n_checks++;
      if ({out_data, out_carry} !== {8'hA5, 1'b0}) begin
        n_fail++; $display("FAIL zero_amt%0d result: got %h/%b want a5/0", i, out_data, out_carry);
      end
      // A request presented while DONE must not disturb the held result.
      in_data = 8'h3C; in_amt = 3'd1; in_mode = 3'b000; in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_data, out_carry, in_ready} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL done_ignores_in%0d: got v=%b d=%h c=%b rdy=%b want 1/a5/0/0",
                 i, out_valid, out_data, out_carry, in_ready);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit tmo;
    run_op(8'hB3, 3'd3, 3'd0, lat, tmo);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, out_carry, in_ready} !== {1'b1, 8'h98, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d: got v=%b d=%h c=%b rdy=%b want 1/98/1/0",
                 i, out_valid, out_data, out_carry, in_ready);
      end
    end
    consume();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL handoff: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat; bit tmo;
    in_data = 8'hFF; in_amt = 3'd6; in_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_carry, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got v=%b d=%h c=%b rdy=%b want 0/00/0/1",
               out_valid, out_data, out_carry, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stale_result: got out_valid=%b want 0", out_valid);
    end
    run_op(8'hB3, 3'd3, 3'd0, lat, tmo);
    n_checks++;
    if (tmo || lat !== 3 || {out_data, out_carry} !== {8'h98, 1'b1}) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d d=%h c=%b want lat=3 d=98 c=1", lat, out_data, out_carry);
    end
    consume();
  endtask

  task automatic test_random();
    int lat, wt; bit tmo;
    logic [W-1:0] d, xd, held;
    logic [A-1:0] a;
    logic [2:0] m;
    logic xc;
    for (int i = 0; i < 60; i++) begin
      d = W'($urandom); a = A'($urandom); m = 3'($urandom);
      model(d, int'(a), m, xd, xc);
      run_op(d, a, m, lat, tmo);
      n_checks++;
      if (tmo || lat !== ((m[2:1] == 2'b11) ? 0 : int'(a))) begin
        n_fail++; $display("FAIL rand%0d latency: mode %0d amt %0d got %0d", i, m, a, lat);
      end
      n_checks++;
      if ({out_data, out_carry} !== {xd, xc}) begin
        n_fail++;
        $display("FAIL rand%0d result: mode %0d d=%h amt %0d got %h/%b want %h/%b",
                 i, m, d, a, out_data, out_carry, xd, xc);
      end
      held = out_data;
      wt = $urandom_range(0, 3);
      repeat (wt) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        n_fail++; $display("FAIL rand%0d hold: got v=%b d=%h want 1/%h", i, out_valid, out_data, held);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_amt();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
